// File: rtl/regfile_pkg.sv
// regfile_pkg: shared sizes, index/word types and the hardwired-zero register index
package regfile_pkg;
    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 5;
    localparam int NUM_REGS   = 2 ** ADDR_WIDTH;
    typedef logic [DATA_WIDTH-1:0] word_t;
    typedef logic [ADDR_WIDTH-1:0] reg_idx_t;
    localparam reg_idx_t ZERO_REG = '0;
endpackage

// File: rtl/regfile_read_port.sv
// regfile_read_port: combinational index-to-data mux that forces the zero register to read 0
module regfile_read_port
    import regfile_pkg::*;
(
    input  word_t    i_regs [NUM_REGS],
    input  reg_idx_t i_addr,
    output word_t    o_data
);
    always_comb o_data = (i_addr == ZERO_REG) ? '0 : i_regs[i_addr];
endmodule

// File: rtl/registers_file.sv
// registers_file: 32 x 32-bit register file, two combinational read ports, one synchronous write port
module registers_file
    import regfile_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     write_enable,
    input  reg_idx_t read_reg1,
    input  reg_idx_t read_reg2,
    input  reg_idx_t write_reg,
    input  word_t    write_data,
    output word_t    read_data1,
    output word_t    read_data2
);
    word_t r_regs [NUM_REGS];
    // reset wins over a write arriving on the same edge; index 0 is never stored
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else if (write_enable && write_reg != ZERO_REG) begin
            r_regs[write_reg] <= write_data;
        end
    end
    regfile_read_port u_rp1 (.i_regs(r_regs), .i_addr(read_reg1), .o_data(read_data1));
    regfile_read_port u_rp2 (.i_regs(r_regs), .i_addr(read_reg2), .o_data(read_data2));
endmodule

// File: tb/tb_registers_file.sv
// tb_registers_file: directed stimulus pushes expected read values into a scoreboard; a monitor pops and compares on each sample
module tb_registers_file;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        write_enable = 1'b0;
    logic [4:0]  read_reg1 = '0;
    logic [4:0]  read_reg2 = '0;
    logic [4:0]  write_reg = '0;
    logic [31:0] write_data = '0;
    logic [31:0] read_data1;
    logic [31:0] read_data2;

    int passed = 0;
    int total  = 0;
    string       q_name [$];
    logic [31:0] q_exp1 [$];
    logic [31:0] q_exp2 [$];
    event        smp;

    registers_file dut (
        .clk(clk), .rst(rst), .write_enable(write_enable),
        .read_reg1(read_reg1), .read_reg2(read_reg2),
        .write_reg(write_reg), .write_data(write_data),
        .read_data1(read_data1), .read_data2(read_data2)
    );

    always #5 clk = ~clk;

    // monitor: each sample event presents both read ports; pop and compare
    initial begin
        forever begin
            @(smp);
            if (q_name.size() == 0) begin
                total++;
                $display("FAIL unexpected_sample: queue empty, rd1=%h rd2=%h", read_data1, read_data2);
            end else begin
                string       nm;
                logic [31:0] e1, e2;
                nm = q_name.pop_front();
                e1 = q_exp1.pop_front();
                e2 = q_exp2.pop_front();
                total++;
                if (read_data1 === e1) passed++;
                else $display("FAIL %s port1: got %h expected %h", nm, read_data1, e1);
                total++;
                if (read_data2 === e2) passed++;
                else $display("FAIL %s port2: got %h expected %h", nm, read_data2, e2);
            end
        end
    end

    task automatic probe(input string nm, input logic [4:0] a1, input logic [4:0] a2,
                         input logic [31:0] e1, input logic [31:0] e2);
        read_reg1 = a1;
        read_reg2 = a2;
        q_name.push_back(nm);
        q_exp1.push_back(e1);
        q_exp2.push_back(e2);
        #1;
        ->smp;
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        write_reg    = a;
        write_data   = d;
        write_enable = 1'b1;
        @(posedge clk);
        #1;
        write_enable = 1'b0;
    endtask

    initial begin
        #12 rst = 1'b0;
        probe("reset_init", 5'd0, 5'd31, 32'h0, 32'h0);

        // async reset pulse between edges after loading values
        wr(5'd5, 32'd55);
        wr(5'd31, 32'd77);
        probe("preload", 5'd5, 5'd31, 32'd55, 32'd77);
        @(posedge clk);
        #3 rst = 1'b1;
        probe("reset_async", 5'd5, 5'd31, 32'h0, 32'h0);
        write_reg = 5'd7; write_data = 32'd99; write_enable = 1'b1;
        @(posedge clk);
        #2 write_enable = 1'b0;
        probe("reset_blocks_write", 5'd7, 5'd5, 32'h0, 32'h0);
        #1 rst = 1'b0;
        for (int i = 0; i < 32; i++) probe("reset_all", 5'(i), 5'(31 - i), 32'h0, 32'h0);

        // basic write/read
        wr(5'd20, 32'd10);
        probe("basic_wr", 5'd20, 5'd20, 32'd10, 32'd10);

        // write disabled
        write_reg = 5'd20; write_data = 32'd120; write_enable = 1'b0;
        @(posedge clk);
        #1;
        probe("wr_disabled", 5'd20, 5'd1, 32'd10, 32'h0);

        // collision: old value before the edge, new after
        @(negedge clk);
        #1;
        write_reg = 5'd1; write_data = 32'd120; write_enable = 1'b1;
        probe("collision_before", 5'd20, 5'd1, 32'd10, 32'h0);
        @(posedge clk);
        #1 write_enable = 1'b0;
        probe("collision_after", 5'd20, 5'd1, 32'd10, 32'd120);

        // zero register ignores writes
        wr(5'd0, 32'hDEADBEEF);
        probe("zero_reg", 5'd0, 5'd0, 32'h0, 32'h0);

        // sweep
        for (int i = 1; i < 32; i++) wr(5'(i), 32'(i * 3 + 1));
        for (int i = 1; i < 32; i++) begin
            int j;
            j = (i % 31) + 1;
            probe("sweep", 5'(i), 5'(j), 32'(i * 3 + 1), 32'(j * 3 + 1));
        end
        probe("sweep_same", 5'd17, 5'd17, 32'd52, 32'd52);
        probe("sweep_zero", 5'd0, 5'd31, 32'h0, 32'd94);

        #5;
        if (q_name.size() != 0) begin
            total++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q_name.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not complete, expected finish before 50000");
        $fatal(1);
    end
endmodule
